// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched
//
// Issue scheduler and in-flight tracker for the four-stage FPU pipeline.
// Each of the four slots holds:
//   - the destination register,
//   - a legal bit (the slot holds a valid, writing instruction),
//   - a countdown of cycles until its result can be forwarded.
// Every clock edge the slots shift toward slot 4, and slot 4 retires into the FPR file.
// Issue stalls on a read-after-write hazard against a slot whose result is not yet
// forwardable. The forward selects pick the youngest (lowest-index) matching slot.
//
// Optional feature: define FPU_SCHED_STATS_EN to build the stall-cycle counter.
// When it is not defined, stall_cnt is tied to zero.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   issue_valid / issue_ready       issue handshake
//   issue_rsa/rsb, issue_use_a/b    source operands and their use flags
//   issue_wr, issue_rd, issue_lat   destination write flag, register, latency (1-4)
//   flush                           kill all in-flight entries
//   rdi_buf_1..4, legal_1..4        per-slot destination register and legal bit
//   rsa_sel, rsb_sel                one-hot forward selects (bit k-1 = slot k)
//   wb_valid, wb_rd                 FPR writeback request from slot 4
//   stall_cnt                       hazard stall-cycle counter
module fpu_issue_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rsa,
  input  logic [4:0]  issue_rsb,
  input  logic        issue_use_a,
  input  logic        issue_use_b,
  input  logic        issue_wr,
  input  logic [4:0]  issue_rd,
  input  logic [2:0]  issue_lat,
  input  logic        flush,
  output logic [4:0]  rdi_buf_1,
  output logic [4:0]  rdi_buf_2,
  output logic [4:0]  rdi_buf_3,
  output logic [4:0]  rdi_buf_4,
  output logic        legal_1,
  output logic        legal_2,
  output logic        legal_3,
  output logic        legal_4,
  output logic [3:0]  rsa_sel,
  output logic [3:0]  rsb_sel,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] stall_cnt
);

  // Index k holds slot k+1.
  logic [3:0][4:0] r_rd;
  logic [3:0]      r_legal;
  logic [3:0][1:0] r_cnt;

  logic       w_accept;
  logic [1:0] w_lat_cnt;
  logic [3:0] w_match_a;
  logic [3:0] w_match_b;
  logic [3:0] w_busy;
  logic       w_hazard;

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  // Clamped latency minus one.
  // Latencies 0 and 1 both mean the result is forwardable straight from slot 1.
  always_comb begin
    w_lat_cnt = 2'd0;
    unique case (issue_lat)
      3'd0, 3'd1: w_lat_cnt = 2'd0;
      3'd2:       w_lat_cnt = 2'd1;
      3'd3:       w_lat_cnt = 2'd2;
      default:    w_lat_cnt = 2'd3;
    endcase
  end

  always_comb begin
    w_match_a = '0;
    w_match_b = '0;
    w_busy    = '0;
    for (int k = 0; k < 4; k++) begin
      w_match_a[k] = issue_use_a & r_legal[k] & (issue_rsa == r_rd[k]);
      w_match_b[k] = issue_use_b & r_legal[k] & (issue_rsb == r_rd[k]);
      w_busy[k]    = (r_cnt[k] != 2'd0);
    end
  end

  assign w_hazard    = |((w_match_a | w_match_b) & w_busy);
  assign issue_ready = ~w_hazard & ~flush;
  assign w_accept    = issue_valid & issue_ready;

  // Isolating the lowest set bit selects the youngest matching producer.
  assign rsa_sel = w_match_a & (~w_match_a + 4'd1);
  assign rsb_sel = w_match_b & (~w_match_b + 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_legal <= '0;
      r_cnt   <= '0;
    end else begin
      // A flush forces w_accept low, so slot 1 takes a bubble.
      r_rd[0]    <= w_accept ? issue_rd : 5'd0;
      r_legal[0] <= w_accept & issue_wr;
      r_cnt[0]   <= w_accept ? w_lat_cnt : 2'd0;
      for (int k = 1; k < 4; k++) begin
        r_rd[k]    <= r_rd[k-1];
        r_legal[k] <= r_legal[k-1] & ~flush;
        r_cnt[k]   <= sat_dec(r_cnt[k-1]);
      end
    end
  end

`ifdef FPU_SCHED_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (issue_valid & w_hazard & ~flush) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

  assign rdi_buf_1 = r_rd[0];
  assign rdi_buf_2 = r_rd[1];
  assign rdi_buf_3 = r_rd[2];
  assign rdi_buf_4 = r_rd[3];
  assign legal_1   = r_legal[0];
  assign legal_2   = r_legal[1];
  assign legal_3   = r_legal[2];
  assign legal_4   = r_legal[3];
  assign wb_valid  = r_legal[3];
  assign wb_rd     = r_rd[3];

endmodule

// File: doc/fpu_issue_sched.md
# fpu_issue_sched

Issue scheduler and in-flight tracker for the four-stage FPU pipeline. It holds the destination register, valid bit and remaining latency of every FPU instruction in flight (slots 1–4), and stalls issue on a read-after-write hazard whose result is not yet forwardable. For each source operand it produces one-hot forwarding selects that pick the youngest matching slot. Slot 4 drives the FPR writeback request. It sits between FPU decode/issue and the FPU operand muxes.

## Interface
Parameters:
- none (slot count fixed at 4; register index 5 bits; latency 1–4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decoded FPU instruction present
- issue_ready  out  1  scheduler accepts the instruction this cycle
- issue_rsa  in  5  source A register
- issue_rsb  in  5  source B register
- issue_use_a  in  1  source A is read
- issue_use_b  in  1  source B is read
- issue_wr  in  1  instruction writes an FPR
- issue_rd  in  5  destination register
- issue_lat  in  3  result latency in cycles, 1–4; 0 is treated as 1; values above 4 are treated as 4
- flush  in  1  kill all in-flight entries
- rdi_buf_1..rdi_buf_4  out  5 each  destination register of slots 1–4
- legal_1..legal_4  out  1 each  slot holds a valid writing instruction
- rsa_sel  out  4  one-hot forward select for source A; bit k-1 = slot k; 0 = read register file
- rsb_sel  out  4  same for source B
- wb_valid  out  1  equals legal_4
- wb_rd  out  5  equals rdi_buf_4
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Per-slot state: rd[4:0], legal, cnt[1:0] (cycles until the result is forwardable).
- Shift every clock edge, unconditionally:
  - slot k+1 takes slot k for k = 1..3.
  - slot 4's previous content retires; the register file is written at that edge.
- Slot 1 load on accept (`issue_valid & issue_ready`):
  - rd = issue_rd
  - legal = issue_wr
  - cnt = clamped(issue_lat) − 1
- Slot 1 load on no accept: legal = 0, rd = 0, cnt = 0 (bubble).
- cnt decrements by one per shift, saturating at 0. Slot 4 always has cnt = 0.
- Match for source A, slot k: `issue_use_a & legal_k & (issue_rsa == rdi_buf_k)`. Source B is the same with rsb/use_b.
- hazard = any matching slot with cnt ≠ 0, on either source.
- `issue_ready = ~hazard & ~flush`.
- rsa_sel / rsb_sel: one-hot of the lowest-index (youngest) matching slot. The select is only meaningful when issue_ready = 1.
- flush: at the next edge all legal bits clear and slot 1 loads a bubble. No instruction is accepted in a flush cycle.
- An instruction with issue_wr = 0 still occupies a slot as a bubble (legal = 0).
- No WAW check is needed: retirement is in order through slot 4.

## Timing
- Reset values: all rdi_buf_k = 0, legal_k = 0, cnt = 0, wb_valid = 0, wb_rd = 0, stall_cnt = 0.
  - Consequently issue_ready = 1 whenever flush = 0, and sel = 0.
- issue_ready, rsa_sel and rsb_sel are combinational from state and issue inputs in the same cycle.
- Accept at edge t: the entry is visible in slot 1 during cycle t+1 and in slot 4 during cycle t+4. Writeback happens at edge t+4.
- Latency L: the result is forwardable from slot L onward. A dependent instruction issues no earlier than the cycle in which the producer occupies slot L.
- Back-to-back dependent issue on an L = 1 producer has zero stall cycles.
- Reset asserted mid-operation clears all slots immediately. In-flight writebacks are lost.

## Configuration
- FPU_SCHED_STATS_EN defined:
  - stall_cnt increments by 1 on every cycle with `issue_valid & hazard & ~flush`.
  - It wraps at 2^32 and is cleared by rst.
- FPU_SCHED_STATS_EN undefined: stall_cnt is tied to 32'd0 and no counter logic is generated. The port is always present.

## Test plan
- Reset, then issue rd=3 with L=1, then a reader of rsa=3 → the reader is accepted the next cycle with rsa_sel=4'b0001, and wb_valid=1 with wb_rd=3 four cycles after the first accept.
- Issue rd=5 with L=4, then a reader of rsb=5 → issue_ready=0 for 3 cycles, then accept with rsb_sel=4'b1000. With FPU_SCHED_STATS_EN, stall_cnt=3.
- Issue rd=7 (L=1) twice in consecutive cycles, then a reader of rsa=7 → rsa_sel=4'b0001 (youngest), not 4'b0010.
- Issue rd=2 with L=3, then assert flush for one cycle → legal_1..4 all 0 the next cycle, wb_valid never asserts for rd=2, and issue_ready=0 during the flush cycle.
- Issue with issue_wr=0, rd=9, then a reader of 9 → no stall and rsa_sel=0. Also, issue_lat=0 behaves exactly as issue_lat=1.
- Assert rst asynchronously while 3 slots are valid → all legal_k and wb_valid drop without waiting for a clock edge, and stall_cnt=0.
